fifo_port_sequencer: RTL and testbench
======================================

Name: fifo_port_sequencer

Overview:
- Sits between a producer stream, a consumer stream and the shared single-port FIFO, whose direction is selected per cycle by WRH_RDL.
- Each cycle it arbitrates one FIFO operation: a write from the producer or a read toward the consumer.
- It generates the FIFO control signals and captures the FIFO's registered read data into a small output buffer.
- It presents valid/ready handshakes on both the producer side and the consumer side.

Parameters:
- DATA_W, 32, data word width (matches the FIFO data width).
- OBUF_DEPTH, 2, output buffer entries (legal range 2..4); sets the maximum number of reads outstanding toward the consumer.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESETL  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  producer has a word.
- IN_DATA  in  DATA_W  producer word.
- IN_READY  out  1  word accepted this cycle when IN_VALID is also 1.
- OUT_VALID  out  1  OUT_DATA holds a word.
- OUT_DATA  out  DATA_W  head of the output buffer.
- OUT_READY  in  1  consumer takes the head word.
- FIFO_ENH  out  1  FIFO operation enable; when 0 the FIFO idles this cycle.
- FIFO_WRH_RDL  out  1  1 = write, 0 = read.
- FIFO_DATAIN  out  DATA_W  write data.
- FIFO_DATAOUT  in  DATA_W  registered read data, valid in the cycle after the read edge.
- FIFO_FULL  in  1  FIFO full flag.
- FIFO_EMPTY  in  1  FIFO empty flag.

Behaviour:
- Reset state (RESETL=0, asynchronous):
  - occ=0, rd_pend=0, last_grant=RD, OUT_VALID=0, OUT_DATA=0.
  - IN_READY=0 and FIFO_ENH=0 are forced combinationally while RESETL=0.
- Request terms (combinational, evaluated each cycle):
  - want_wr = IN_VALID & ~FIFO_FULL.
  - want_rd = ~FIFO_EMPTY & (occ + rd_pend < OBUF_DEPTH). Reads are credit-limited so a captured word always has a buffer slot.
- Grant rules:
  - Only want_wr: grant WR.
  - Only want_rd: grant RD.
  - Both: grant the opposite of last_grant (alternating priority); last_grant updates only on a contested cycle.
  - Neither: FIFO_ENH=0; FIFO_WRH_RDL holds 1 and FIFO_DATAIN = IN_DATA so the outputs do not toggle.
- WR grant:
  - FIFO_ENH=1, FIFO_WRH_RDL=1, FIFO_DATAIN=IN_DATA (combinational pass-through), IN_READY=1.
  - IN_READY=1 only on a WR grant; it is 0 whenever FIFO_FULL=1 or RD wins.
- RD grant:
  - FIFO_ENH=1, FIFO_WRH_RDL=0, rd_pend<=1.
  - Otherwise rd_pend<=0, so at most one read is in flight and consecutive reads are allowed.
- Capture:
  - In the cycle with rd_pend=1, FIFO_DATAOUT is written into the output buffer tail at the rising edge; occ increments.
- Pop:
  - OUT_VALID = (occ != 0). OUT_DATA = buffer head, registered, never combinational from FIFO_DATAOUT.
  - OUT_VALID & OUT_READY pops the head.
  - Capture and pop in the same cycle leave occ unchanged and preserve order.
- Latency:
  - Read grant to OUT_VALID: 2 cycles when the buffer is empty.
  - Input write to FIFO: 0 cycles (same edge).
- Ordering: output order equals FIFO read order; no word is dropped or duplicated.
- Boundary conditions:
  - FULL and EMPTY both 1: illegal, no operation issued.
  - occ never exceeds OBUF_DEPTH (assertion).
  - Pointer wrap in the buffer is modulo OBUF_DEPTH.
- Reset mid-operation: in-flight read data and buffered words are discarded. The FIFO is reset by the same system reset (RESETH = ~RESETL at top level).

Decomposition:
- Package fifo_pkg holds:
  - DATA_W default.
  - Opcode constants OP_WR=1'b1, OP_RD=1'b0.
  - Grant encoding used for last_grant.
- Sub-module fifo_seq_obuf: OBUF_DEPTH-entry circular output buffer with push/pop, occ count, and registered head output.
- Arbitration and credit logic stay in fifo_port_sequencer.

Test Plan:
- Reset: hold RESETL=0 for 3 cycles with IN_VALID=1 → IN_READY=0, FIFO_ENH=0, OUT_VALID=0, OUT_DATA=0.
- Fill, no drain: OUT_READY=0, stream words 1..40 into a 32-deep FIFO model →
  - First two RD grants capture 1 and 2 (OUT_VALID=1, OUT_DATA=1).
  - Writes stall with IN_READY=0 once FULL=1, after 34 words are accepted in total.
  - No further FIFO_ENH reads occur.
- Contention: IN_VALID=1 and OUT_READY=1 continuously with the FIFO non-empty → grants alternate WR,RD,WR,RD; consumer receives consecutive values in order with no gaps or duplicates.
- Backpressure release: after the fill case, set OUT_READY=1 → consumer receives 1..34 in order; RD grants never exceed the credit.
- Empty/idle: FIFO empty, IN_VALID=0 → FIFO_ENH=0 every cycle; after one write of 0xA5, OUT_DATA=0xA5 appears 3 cycles after the write edge with OUT_READY=1.
- Reset mid-read: drive RESETL=0 in the cycle with rd_pend=1 → OUT_VALID=0 immediately and stays 0 after release; no stale capture.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO port sequencer: data width default,
// FIFO opcodes and the grant encoding remembered for alternating priority.
package fifo_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

endpackage

// File: rtl/fifo_seq_obuf.sv
// Small circular output buffer that holds words read back from the FIFO.
// The head word is kept in its own register so the consumer never sees FIFO data combinationally.
module fifo_seq_obuf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   occ,
  output logic                         valid,
  output logic [DATA_W-1:0]            head
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop_ok;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign valid  = (occ != '0);
  assign pop_ok = pop & valid;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      head   <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);

      case ({push, pop_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase

      // Next head is the following stored word, or the incoming word when the buffer would drain.
      if (pop_ok) begin
        if (occ > OCC_W'(1))
          head <= mem[ptr_inc(rd_ptr)];
        else if (push)
          head <= push_data;
      end else if ((occ == '0) && push) begin
        head <= push_data;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) occ <= OCC_W'(DEPTH));

endmodule

// File: rtl/fifo_port_sequencer.sv
// Arbitrates one shared single-port FIFO between a producer and a consumer,
// alternating priority when both want the FIFO and limiting reads to free output-buffer slots.
module fifo_port_sequencer
  import fifo_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int OBUF_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RESETL,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              IN_READY,
  output logic              OUT_VALID,
  output logic [DATA_W-1:0] OUT_DATA,
  input  logic              OUT_READY,
  output logic              FIFO_ENH,
  output logic              FIFO_WRH_RDL,
  output logic [DATA_W-1:0] FIFO_DATAIN,
  input  logic [DATA_W-1:0] FIFO_DATAOUT,
  input  logic              FIFO_FULL,
  input  logic              FIFO_EMPTY
);

  localparam int OCC_W = $clog2(OBUF_DEPTH + 1);

  logic [OCC_W-1:0] occ;
  logic             rd_pend;
  grant_t           last_grant;
  logic             want_wr;
  logic             want_rd;
  logic             contested;
  logic             grant_wr;
  logic             grant_rd;
  logic             pop;

  // A read is only requested when the word it returns is guaranteed a buffer slot.
  always_comb begin
    want_wr   = IN_VALID & ~FIFO_FULL;
    want_rd   = ~FIFO_EMPTY & ((int'(occ) + int'(rd_pend)) < OBUF_DEPTH);
    contested = want_wr & want_rd;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    if (RESETL) begin
      if (contested) begin
        grant_wr = (last_grant == GRANT_RD);
        grant_rd = (last_grant == GRANT_WR);
      end else begin
        grant_wr = want_wr;
        grant_rd = want_rd;
      end
    end
  end

  assign FIFO_ENH     = grant_wr | grant_rd;
  assign FIFO_WRH_RDL = grant_rd ? OP_RD : OP_WR;
  assign FIFO_DATAIN  = IN_DATA;
  assign IN_READY     = grant_wr;

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      rd_pend    <= 1'b0;
      last_grant <= GRANT_RD;
    end else begin
      rd_pend <= grant_rd;
      if (contested) last_grant <= grant_wr ? GRANT_WR : GRANT_RD;
    end
  end

  assign pop = OUT_VALID & OUT_READY;

  fifo_seq_obuf #(
    .DATA_W (DATA_W),
    .DEPTH  (OBUF_DEPTH)
  ) u_obuf (
    .clk       (CLK),
    .rst_n     (RESETL),
    .push      (rd_pend),
    .push_data (FIFO_DATAOUT),
    .pop       (pop),
    .occ       (occ),
    .valid     (OUT_VALID),
    .head      (OUT_DATA)
  );

endmodule

// File: tb/tb_fifo_port_sequencer.sv
// Bench for fifo_port_sequencer with a 32-deep behavioural FIFO attached and a
// word-level reference model of credits, arbitration and buffered output order.
module tb_fifo_port_sequencer;

  localparam int DW  = 32;
  localparam int OBD = 2;
  localparam int FD  = 32;

  logic          clk = 1'b0;
  logic          clk_run = 1'b0;
  logic          resetl = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          fifo_enh;
  logic          fifo_wrh_rdl;
  logic [DW-1:0] fifo_datain;
  logic [DW-1:0] fifo_dataout;
  logic          fifo_full;
  logic          fifo_empty;

  logic          tbl_mode = 1'b1;
  logic          tbl_full = 1'b0;
  logic          tbl_empty = 1'b1;
  logic          env_full = 1'b0;
  logic          env_empty = 1'b1;
  logic [DW-1:0] env_dout = '0;
  logic [DW-1:0] fq[$];

  logic          s_enh = 1'b0;
  logic          s_wrh = 1'b1;
  logic [DW-1:0] s_din = '0;
  logic          s_ready = 1'b0;
  logic          s_ov = 1'b0;
  logic [DW-1:0] s_od = '0;

  int            tests = 0;
  int            fails = 0;

  int            m_out = 0;
  logic          m_pend = 1'b0;
  logic          m_last_wr = 1'b0;
  logic [DW-1:0] m_cap = '0;
  logic [DW-1:0] m_obuf[$];
  logic [DW-1:0] m_acc[$];
  logic [DW-1:0] rx[$];
  logic          e_gw = 1'b0;
  logic          e_gr = 1'b0;
  logic          e_con = 1'b0;
  int            acc_cnt = 0;
  int            rd_cnt = 0;

  typedef struct {
    logic rl, iv, full, empty;
    logic rdy, enh, wrh;
  } vec_t;

  vec_t tbl[8];

  typedef struct {
    int cycles;
    int iv_pct;
    int or_pct;
  } phase_t;

  phase_t phases[4];

  fifo_port_sequencer #(.DATA_W(DW), .OBUF_DEPTH(OBD)) dut (
    .CLK          (clk),
    .RESETL       (resetl),
    .IN_VALID     (in_valid),
    .IN_DATA      (in_data),
    .IN_READY     (in_ready),
    .OUT_VALID    (out_valid),
    .OUT_DATA     (out_data),
    .OUT_READY    (out_ready),
    .FIFO_ENH     (fifo_enh),
    .FIFO_WRH_RDL (fifo_wrh_rdl),
    .FIFO_DATAIN  (fifo_datain),
    .FIFO_DATAOUT (fifo_dataout),
    .FIFO_FULL    (fifo_full),
    .FIFO_EMPTY   (fifo_empty)
  );

  always #5 if (clk_run) clk = ~clk;

  assign fifo_full    = tbl_mode ? tbl_full  : env_full;
  assign fifo_empty   = tbl_mode ? tbl_empty : env_empty;
  assign fifo_dataout = env_dout;

  // Single-port FIFO driven by the control values sampled at the preceding falling edge.
  always @(posedge clk or negedge resetl) begin : env_fifo
    int n;
    logic [DW-1:0] w;
    if (!resetl) begin
      fq.delete();
      env_dout  <= '0;
      env_full  <= 1'b0;
      env_empty <= 1'b1;
    end else begin
      n = fq.size();
      if (s_enh && s_wrh && n < FD) begin
        fq.push_back(s_din);
        n++;
      end else if (s_enh && !s_wrh && n > 0) begin
        w = fq.pop_front();
        env_dout <= w;
        n--;
      end
      env_full  <= (n == FD);
      env_empty <= (n == 0);
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0;
    m_pend = 1'b0;
    m_last_wr = 1'b0;
    m_obuf.delete();
    m_acc.delete();
    e_gw = 1'b0;
    e_gr = 1'b0;
    e_con = 1'b0;
  endtask

  // Falling edge: sample the DUT, predict this cycle's decision from the model, compare.
  task automatic sample_and_check();
    logic ww, wr;
    s_enh = fifo_enh;
    s_wrh = fifo_wrh_rdl;
    s_din = fifo_datain;
    s_ready = in_ready;
    s_ov = out_valid;
    s_od = out_data;
    if (s_ov && out_ready) rx.push_back(s_od);
    if (s_ready && in_valid) acc_cnt++;
    if (s_enh && !s_wrh) rd_cnt++;
    if (!resetl) begin
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_enh", fifo_enh, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chkw("rst_out_data", out_data, '0);
      e_gw = 1'b0;
      e_gr = 1'b0;
      e_con = 1'b0;
      return;
    end
    ww = in_valid && !fifo_full;
    wr = !fifo_empty && (m_out < OBD);
    e_con = ww && wr;
    if (e_con) begin
      e_gw = !m_last_wr;
      e_gr = m_last_wr;
    end else begin
      e_gw = ww;
      e_gr = wr;
    end
    chk1("in_ready", in_ready, e_gw);
    chk1("fifo_enh", fifo_enh, e_gw | e_gr);
    chk1("fifo_wrh_rdl", fifo_wrh_rdl, !e_gr);
    chkw("fifo_datain", fifo_datain, in_data);
    chk1("out_valid", out_valid, m_obuf.size() != 0);
    if (m_obuf.size() != 0) chkw("out_data", out_data, m_obuf[0]);
    if (m_obuf.size() != 0 && out_ready && m_acc.size() != 0)
      chkw("stream_order", out_data, m_acc[0]);
    if (m_pend) m_cap = fifo_dataout;
  endtask

  // Rising edge: advance the model by whole words and credits.
  task automatic model_update();
    logic [DW-1:0] t;
    if (!resetl) return;
    if (m_obuf.size() != 0 && out_ready) begin
      t = m_obuf.pop_front();
      if (m_acc.size() != 0) t = m_acc.pop_front();
      m_out--;
    end
    if (m_pend) m_obuf.push_back(m_cap);
    m_pend = e_gr;
    if (e_gr) m_out++;
    if (e_con) m_last_wr = e_gw;
    if (e_gw) m_acc.push_back(in_data);
  endtask

  task automatic applyStimulus(input logic iv, input logic [DW-1:0] d, input logic ordy);
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    @(negedge clk);
    sample_and_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    int nxt;
    int cnt;
    logic found;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    phases[0] = '{200, 50, 50};
    phases[1] = '{200, 90, 20};
    phases[2] = '{200, 20, 90};
    phases[3] = '{200, 100, 100};

    // Combinational grant table with the clock stopped, straight out of reset.
    #1 resetl = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      resetl    = tbl[i].rl;
      in_valid  = tbl[i].iv;
      tbl_full  = tbl[i].full;
      tbl_empty = tbl[i].empty;
      in_data   = $urandom;
      #1;
      chk1($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].rdy);
      chk1($sformatf("tbl%0d_enh", i), fifo_enh, tbl[i].enh);
      chk1($sformatf("tbl%0d_wrh_rdl", i), fifo_wrh_rdl, tbl[i].wrh);
      chkw($sformatf("tbl%0d_datain", i), fifo_datain, in_data);
      chk1($sformatf("tbl%0d_out_valid", i), out_valid, 1'b0);
    end

    tbl_mode = 1'b0;
    resetl = 1'b0;
    model_reset();
    clk_run = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h1234, 1'b0);
    resetl = 1'b1;

    // Fill with no drain: 32 FIFO words plus 2 buffered reads.
    nxt = 1;
    acc_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(nxt <= 40, nxt, 1'b0);
      if (s_ready && nxt <= 40) nxt++;
    end
    rd_cnt = 0;
    for (int i = 0; i < 20; i++) applyStimulus(nxt <= 40, nxt, 1'b0);
    chki("fill_accepted", acc_cnt, 34);
    chki("fill_no_more_reads", rd_cnt, 0);
    chk1("fill_in_ready_stall", s_ready, 1'b0);
    chk1("fill_out_valid", s_ov, 1'b1);
    chkw("fill_out_data", s_od, 32'd1);

    // Backpressure release.
    rx.delete();
    for (int i = 0; i < 90; i++) applyStimulus(1'b0, '0, 1'b1);
    chki("drain_count", rx.size(), 34);
    for (int i = 0; i < rx.size() && i < 34; i++)
      chkw($sformatf("drain_word%0d", i), rx[i], DW'(i + 1));

    // Continuous contention with producer and consumer both active.
    rx.delete();
    nxt = 100;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b1, nxt, 1'b1);
      if (s_ready) nxt++;
    end
    chki("contention_rx_min", (rx.size() >= 20) ? 1 : 0, 1);
    for (int i = 0; i < rx.size(); i++)
      chkw($sformatf("contention_seq%0d", i), rx[i], DW'(100 + i));

    for (int p = 0; p < 4; p++)
      for (int i = 0; i < phases[p].cycles; i++)
        applyStimulus(($urandom % 100) < phases[p].iv_pct, $urandom,
                      ($urandom % 100) < phases[p].or_pct);

    // Empty and idle, then a single write observed three cycles later.
    for (int i = 0; i < 90; i++) applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, $urandom, 1'b1);
      chk1("idle_enh", s_enh, 1'b0);
    end
    applyStimulus(1'b1, 32'hA5, 1'b1);
    chk1("a5_accepted", s_ready, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    chk1("a5_lat1_out_valid", s_ov, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    chk1("a5_lat2_out_valid", s_ov, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    chk1("a5_lat3_out_valid", s_ov, 1'b1);
    chkw("a5_lat3_out_data", s_od, 32'hA5);

    // Reset while a read is in flight and a word is already buffered.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(11 * (i + 1)), 1'b0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_pend && m_obuf.size() != 0) found = 1'b1;
      else applyStimulus(1'b0, '0, 1'b0);
    end
    chk1("midread_reached", found, 1'b1);
    chk1("midread_pre_out_valid", out_valid, 1'b1);
    resetl = 1'b0;
    model_reset();
    #1;
    chk1("midread_out_valid_now", out_valid, 1'b0);
    chkw("midread_out_data_now", out_data, '0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    resetl = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      if (s_ov) cnt++;
    end
    chki("midread_no_stale", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
